// File: rtl/titan_pkg.sv
// ---------------------------------------------------------------------------
// titan_pkg
// Shared definitions for the Titan register file slice.
//  - Default widths and the link-register index used by regfile_sb.
//  - wrSrcE: which write port(s) commit on a given edge.
//  - arbitrate(): resolves the general and link write ports into one wrSrcE.
// No ports (package).
// ---------------------------------------------------------------------------
package titan_pkg;

  localparam int DATA_W_DEF   = 32;
  localparam int ADDR_W_DEF   = 5;
  localparam int LINK_REG_DEF = 31;
  localparam int ZERO_REG_DEF = 1;
  localparam int CNT_W_DEF    = 16;

  // Which storage ports commit this cycle. Both ports can commit together
  // when they target different registers.
  typedef enum logic [1:0] {
    WR_NONE    = 2'd0,
    WR_GENERAL = 2'd1,
    WR_LINK    = 2'd2,
    WR_BOTH    = 2'd3
  } wrSrcE;

  // genOk/linkOk are the port enables with discarded targets already removed.
  // collide means the general port targets the link register, in which case
  // the general port wins and the link write is dropped.
  function automatic wrSrcE arbitrate(input logic genOk,
                                      input logic linkOk,
                                      input logic collide);
    wrSrcE src;
    src = WR_NONE;
    if (genOk && linkOk && !collide) begin
      src = WR_BOTH;
    end else if (genOk) begin
      src = WR_GENERAL;
    end else if (linkOk && !collide) begin
      src = WR_LINK;
    end
    return src;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// ---------------------------------------------------------------------------
// reg_scoreboard
// Per-register busy tracking for the issue stage plus a stall counter.
// Ports:
//  clk, reset        clock, asynchronous active-high reset
//  clrVec            one-hot-or-two vector of registers written this cycle
//  issue_valid       decode presents an instruction
//  issue_dest        its destination index
//  issue_has_dest    instruction writes a register
//  issue_use_rt      instruction reads rt
//  rs_addr, rt_addr  source indices of the presented instruction
//  issue_stall       combinational hazard flag
//  busy              registered busy vector
//  stall_cnt         saturating count of stalled cycles
// ---------------------------------------------------------------------------
module reg_scoreboard
  import titan_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DEPTH-1:0]  clrVec,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              issue_has_dest,
  input  logic              issue_use_rt,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic              issue_stall,
  output logic [DEPTH-1:0]  busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [DEPTH-1:0] effBusy;
  logic [DEPTH-1:0] setVec;
  logic             destAllowed;

  // A register being written this very cycle is no longer a hazard: the
  // bypass in the read path already delivers the new value.
  assign effBusy = busy & ~clrVec;

  // Hazard detection: RAW on rs, RAW on rt when used, WAW on the destination.
  always_comb begin
    issue_stall = 1'b0;
    if (issue_valid) begin
      issue_stall = effBusy[rs_addr]
                  | (issue_use_rt & effBusy[rt_addr])
                  | (issue_has_dest & effBusy[issue_dest]);
    end
  end

  // Register 0 is never marked busy when it is hard-wired to zero, since
  // nothing will ever write it back.
  assign destAllowed = !((ZERO_REG != 0) && (issue_dest == '0));

  always_comb begin
    setVec = '0;
    if (issue_valid && issue_has_dest && !issue_stall && destAllowed) begin
      setVec[issue_dest] = 1'b1;
    end
  end

  // Clear first, then OR in the new reservation so that a set and a clear of
  // the same index on one edge leaves the register busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= '0;
    end else begin
      busy <= (busy & ~clrVec) | setVec;
    end
  end

  // Saturating stall counter; holds at all-ones rather than wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (issue_stall && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// ---------------------------------------------------------------------------
// regfile_sb
// Titan register file: DEPTH x DATA_W storage, two combinational read ports,
// a general writeback port and a dedicated link-register write port, with
// same-cycle write-to-read bypass and an issue scoreboard (reg_scoreboard).
// Ports:
//  clk, reset                       clock, asynchronous active-high reset
//  wr_en, wr_addr, wr_data          writeback port
//  link_wr_en, link_wdata           link-register write port
//  rs_addr/rs_data, rt_addr/rt_data read ports A and B (combinational)
//  link_rdata                       current link register (combinational)
//  issue_valid, issue_dest,
//  issue_has_dest, issue_use_rt     instruction presented by decode
//  issue_stall                      hazard, hold decode
//  busy                             scoreboard bits
//  stall_cnt                        saturating stalled-cycle counter
// ---------------------------------------------------------------------------
module regfile_sb
  import titan_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int ZERO_REG = ZERO_REG_DEF,
  parameter int CNT_W    = CNT_W_DEF,
  localparam int DEPTH   = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              link_wr_en,
  input  logic [DATA_W-1:0] link_wdata,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [DATA_W-1:0] rs_data,
  output logic [DATA_W-1:0] rt_data,
  output logic [DATA_W-1:0] link_rdata,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              issue_has_dest,
  input  logic              issue_use_rt,
  output logic              issue_stall,
  output logic [DEPTH-1:0]  busy,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [ADDR_W-1:0] LINK_IDX = ADDR_W'(LINK_REG);
  localparam bit                LINK_IS_ZERO = (ZERO_REG != 0) && (LINK_REG == 0);

  logic [DATA_W-1:0] mem [DEPTH];

  logic       genOk;
  logic       linkOk;
  logic       collide;
  wrSrcE      wrSrc;
  logic       genCommit;
  logic       linkCommit;
  logic [DEPTH-1:0] clrVec;

  // Writes to a hard-wired zero register are discarded before arbitration so
  // they neither store, bypass, nor clear a busy bit.
  assign genOk   = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign linkOk  = link_wr_en && !LINK_IS_ZERO;
  assign collide = wr_en && (wr_addr == LINK_IDX);

  assign wrSrc      = arbitrate(genOk, linkOk, collide);
  assign genCommit  = (wrSrc == WR_GENERAL) || (wrSrc == WR_BOTH);
  assign linkCommit = (wrSrc == WR_LINK)    || (wrSrc == WR_BOTH);

  // Storage. Reset clears every entry; a write presented while reset is
  // asserted never lands because the reset branch owns the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (genCommit) begin
        mem[wr_addr] <= wr_data;
      end
      if (linkCommit) begin
        mem[LINK_IDX] <= link_wdata;
      end
    end
  end

  // Registers receiving a committed write this cycle; the scoreboard uses it
  // both to retire busy bits and to mask hazards the bypass already covers.
  always_comb begin
    clrVec = '0;
    if (genCommit) begin
      clrVec[wr_addr] = 1'b1;
    end
    if (linkCommit) begin
      clrVec[LINK_IDX] = 1'b1;
    end
  end

  // One read path shared by all three read outputs: zero register first, then
  // whichever committed write targets the index, then stored contents.
  function automatic logic [DATA_W-1:0] readPort(input logic [ADDR_W-1:0] idx);
    logic [DATA_W-1:0] val;
    if ((ZERO_REG != 0) && (idx == '0)) begin
      val = '0;
    end else if (genCommit && (wr_addr == idx)) begin
      val = wr_data;
    end else if (linkCommit && (LINK_IDX == idx)) begin
      val = link_wdata;
    end else begin
      val = mem[idx];
    end
    return val;
  endfunction

  always_comb begin
    rs_data    = readPort(rs_addr);
    rt_data    = readPort(rt_addr);
    link_rdata = readPort(LINK_IDX);
  end

  reg_scoreboard #(
    .ADDR_W   (ADDR_W),
    .ZERO_REG (ZERO_REG),
    .CNT_W    (CNT_W)
  ) uScoreboard (
    .clk            (clk),
    .reset          (reset),
    .clrVec         (clrVec),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_has_dest (issue_has_dest),
    .issue_use_rt   (issue_use_rt),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .issue_stall    (issue_stall),
    .busy           (busy),
    .stall_cnt      (stall_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// ---------------------------------------------------------------------------
// tb_regfile_sb
// Self-checking bench for regfile_sb (DATA_W=32, ADDR_W=5, LINK_REG=31,
// ZERO_REG=1, CNT_W=4). Expected values are queued when stimulus is driven
// and popped when the corresponding output is sampled.
// ---------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;
  localparam int NREG = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          link_wr_en;
  logic [DW-1:0] link_wdata;
  logic [AW-1:0] rs_addr;
  logic [AW-1:0] rt_addr;
  logic [DW-1:0] rs_data;
  logic [DW-1:0] rt_data;
  logic [DW-1:0] link_rdata;
  logic          issue_valid;
  logic [AW-1:0] issue_dest;
  logic          issue_has_dest;
  logic          issue_use_rt;
  logic          issue_stall;
  logic [NREG-1:0] busy;
  logic [CW-1:0] stall_cnt;

  int nChecks = 0;
  int nFail = 0;
  logic [31:0] expQ[$];
  logic [31:0] expVal;
  int expCnt = 0;
  logic [31:0] model [NREG];

  always #5 clk = ~clk;

  regfile_sb #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .LINK_REG (31),
    .ZERO_REG (1),
    .CNT_W    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .wr_en          (wr_en),
    .wr_addr        (wr_addr),
    .wr_data        (wr_data),
    .link_wr_en     (link_wr_en),
    .link_wdata     (link_wdata),
    .rs_addr        (rs_addr),
    .rt_addr        (rt_addr),
    .rs_data        (rs_data),
    .rt_data        (rt_data),
    .link_rdata     (link_rdata),
    .issue_valid    (issue_valid),
    .issue_dest     (issue_dest),
    .issue_has_dest (issue_has_dest),
    .issue_use_rt   (issue_use_rt),
    .issue_stall    (issue_stall),
    .busy           (busy),
    .stall_cnt      (stall_cnt)
  );

  // Safety net so the run always ends even if something wedges.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired actual=running required=finished");
    $fatal(1, "[TB] watchdog");
  end

  task applyStimulus();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    link_wr_en = 1'b0; link_wdata = '0;
    rs_addr = '0; rt_addr = '0;
    issue_valid = 1'b0; issue_dest = '0;
    issue_has_dest = 1'b0; issue_use_rt = 1'b0;
  endtask

  // Saturating counter model for the CW-bit stall counter.
  task bumpCnt();
    expCnt = (expCnt == (1 << CW) - 1) ? expCnt : expCnt + 1;
  endtask

  task test_reset();
    applyStimulus();
    #1 reset = 1'b1;
    #1;
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL reset_rs actual=%0h required=%0h", rs_data, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL reset_busy actual=%0h required=%0h", busy, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({28'd0, stall_cnt} !== expVal) begin nFail++; $display("[TB] FAIL reset_cnt actual=%0h required=%0h", stall_cnt, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL reset_stall actual=%0h required=%0h", issue_stall, expVal); end
    @(negedge clk);
    reset = 1'b0;
    expCnt = 0;
  endtask

  task test_bypass();
    @(negedge clk);
    applyStimulus();
    wr_en = 1'b1; wr_addr = 5'd2; wr_data = 32'd41; rs_addr = 5'd2;
    expQ.push_back(32'd41);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL bypass_rs actual=%0h required=%0h", rs_data, expVal); end
    @(negedge clk);
    wr_en = 1'b0; rt_addr = 5'd2;
    expQ.push_back(32'd41);
    expQ.push_back(32'd41);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL stored_rs actual=%0h required=%0h", rs_data, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (rt_data !== expVal) begin nFail++; $display("[TB] FAIL stored_rt actual=%0h required=%0h", rt_data, expVal); end
  endtask

  task test_zero_reg();
    @(negedge clk);
    applyStimulus();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'hFFFF_FFFF; rs_addr = 5'd0;
    issue_valid = 1'b1; issue_has_dest = 1'b1; issue_dest = 5'd0;
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL zero_bypass actual=%0h required=%0h", rs_data, expVal); end
    @(negedge clk);
    applyStimulus();
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL zero_stored actual=%0h required=%0h", rs_data, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL zero_busy actual=%0h required=%0h", busy, expVal); end
  endtask

  task test_link();
    @(negedge clk);
    applyStimulus();
    link_wr_en = 1'b1; link_wdata = 32'h100;
    wr_en = 1'b1; wr_addr = 5'd31; wr_data = 32'h200;
    expQ.push_back(32'h200);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (link_rdata !== expVal) begin nFail++; $display("[TB] FAIL link_collide_bypass actual=%0h required=%0h", link_rdata, expVal); end
    @(negedge clk);
    applyStimulus();
    rs_addr = 5'd31;
    expQ.push_back(32'h200);
    expQ.push_back(32'h200);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (link_rdata !== expVal) begin nFail++; $display("[TB] FAIL link_collide_stored actual=%0h required=%0h", link_rdata, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL link_rs31 actual=%0h required=%0h", rs_data, expVal); end
    link_wr_en = 1'b1; link_wdata = 32'h300;
    @(negedge clk);
    applyStimulus();
    expQ.push_back(32'h300);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (link_rdata !== expVal) begin nFail++; $display("[TB] FAIL link_only actual=%0h required=%0h", link_rdata, expVal); end
  endtask

  task test_raw();
    @(negedge clk);
    applyStimulus();
    issue_valid = 1'b1; issue_has_dest = 1'b1; issue_dest = 5'd5; rs_addr = 5'd1;
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL raw_accept actual=%0h required=%0h", issue_stall, expVal); end
    @(negedge clk);
    issue_dest = 5'd6; rs_addr = 5'd5;
    expQ.push_back(32'h0000_0020);
    expQ.push_back(32'd1);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL raw_busy5 actual=%0h required=%0h", busy, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL raw_stall actual=%0h required=%0h", issue_stall, expVal); end
    @(negedge clk);
    bumpCnt();
    expQ.push_back(32'(expCnt));
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'd55;
    expQ.push_back(32'd0);
    expQ.push_back(32'd55);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if ({28'd0, stall_cnt} !== expVal) begin nFail++; $display("[TB] FAIL raw_cnt actual=%0h required=%0h", stall_cnt, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL raw_release actual=%0h required=%0h", issue_stall, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL raw_bypass actual=%0h required=%0h", rs_data, expVal); end
    @(negedge clk);
    applyStimulus();
    rs_addr = 5'd5;
    expQ.push_back(32'h0000_0040);
    expQ.push_back(32'd55);
    expQ.push_back(32'(expCnt));
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL raw_busy_after actual=%0h required=%0h", busy, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL raw_stored actual=%0h required=%0h", rs_data, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({28'd0, stall_cnt} !== expVal) begin nFail++; $display("[TB] FAIL raw_cnt_hold actual=%0h required=%0h", stall_cnt, expVal); end
    wr_en = 1'b1; wr_addr = 5'd6; wr_data = 32'd66;
    @(negedge clk);
    applyStimulus();
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL raw_busy_clear actual=%0h required=%0h", busy, expVal); end
  endtask

  task test_waw();
    @(negedge clk);
    applyStimulus();
    issue_valid = 1'b1; issue_has_dest = 1'b1; issue_dest = 5'd7; rs_addr = 5'd1;
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd77;
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL waw_accept actual=%0h required=%0h", issue_stall, expVal); end
    @(negedge clk);
    wr_en = 1'b0;
    expQ.push_back(32'h0000_0080);
    expQ.push_back(32'd1);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL waw_set_wins actual=%0h required=%0h", busy, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL waw_stall actual=%0h required=%0h", issue_stall, expVal); end
    @(negedge clk);
    bumpCnt();
    issue_valid = 1'b0;
    expQ.push_back(32'(expCnt));
    expQ.push_back(32'h0000_0080);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if ({28'd0, stall_cnt} !== expVal) begin nFail++; $display("[TB] FAIL waw_cnt actual=%0h required=%0h", stall_cnt, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL waw_busy_hold actual=%0h required=%0h", busy, expVal); end
  endtask

  task test_saturate_reset();
    @(negedge clk);
    applyStimulus();
    issue_valid = 1'b1; rs_addr = 5'd7;
    expQ.push_back(32'd1);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL sat_stall actual=%0h required=%0h", issue_stall, expVal); end
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      bumpCnt();
    end
    @(negedge clk);
    expQ.push_back(32'd15);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if ({28'd0, stall_cnt} !== expVal) begin nFail++; $display("[TB] FAIL sat_cnt actual=%0h required=%0h", stall_cnt, expVal); end
    rt_addr = 5'd2;
    reset = 1'b1;
    expCnt = 0;
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (busy !== expVal) begin nFail++; $display("[TB] FAIL midreset_busy actual=%0h required=%0h", busy, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({28'd0, stall_cnt} !== expVal) begin nFail++; $display("[TB] FAIL midreset_cnt actual=%0h required=%0h", stall_cnt, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (rt_data !== expVal) begin nFail++; $display("[TB] FAIL midreset_reg2 actual=%0h required=%0h", rt_data, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (link_rdata !== expVal) begin nFail++; $display("[TB] FAIL midreset_link actual=%0h required=%0h", link_rdata, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if ({31'd0, issue_stall} !== expVal) begin nFail++; $display("[TB] FAIL midreset_stall actual=%0h required=%0h", issue_stall, expVal); end
    issue_valid = 1'b0; rs_addr = 5'd1;
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'd9;
    @(negedge clk);
    applyStimulus();
    reset = 1'b0;
    rs_addr = 5'd3;
    expQ.push_back(32'd0);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL reset_write_dropped actual=%0h required=%0h", rs_data, expVal); end
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
  endtask

  // General and link writes to different registers every cycle, reading the
  // previous cycle's target from storage and the current one via bypass.
  task test_back_to_back();
    logic [31:0] d;
    int dst;
    int src;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      applyStimulus();
      d = $urandom;
      dst = 8 + i;
      src = (i == 0) ? 0 : dst - 1;
      wr_en = 1'b1; wr_addr = AW'(dst); wr_data = d;
      link_wr_en = 1'b1; link_wdata = d ^ 32'h0000_FFFF;
      rt_addr = AW'(dst); rs_addr = AW'(src);
      expQ.push_back(d);
      expQ.push_back(model[src]);
      expQ.push_back(d ^ 32'h0000_FFFF);
      #1;
      expVal = expQ.pop_front(); nChecks++;
      if (rt_data !== expVal) begin nFail++; $display("[TB] FAIL b2b_rt_bypass[%0d] actual=%0h required=%0h", i, rt_data, expVal); end
      expVal = expQ.pop_front(); nChecks++;
      if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL b2b_rs_stored[%0d] actual=%0h required=%0h", i, rs_data, expVal); end
      expVal = expQ.pop_front(); nChecks++;
      if (link_rdata !== expVal) begin nFail++; $display("[TB] FAIL b2b_link[%0d] actual=%0h required=%0h", i, link_rdata, expVal); end
      model[dst] = d;
      model[31] = d ^ 32'h0000_FFFF;
    end
    @(negedge clk);
    applyStimulus();
    rs_addr = 5'd15; rt_addr = 5'd31;
    expQ.push_back(model[15]);
    expQ.push_back(model[31]);
    #1;
    expVal = expQ.pop_front(); nChecks++;
    if (rs_data !== expVal) begin nFail++; $display("[TB] FAIL b2b_final_rs actual=%0h required=%0h", rs_data, expVal); end
    expVal = expQ.pop_front(); nChecks++;
    if (rt_data !== expVal) begin nFail++; $display("[TB] FAIL b2b_final_rt actual=%0h required=%0h", rt_data, expVal); end
  endtask

  task checkOutput();
    nChecks++;
    if (expQ.size() != 0) begin
      nFail++;
      $display("[TB] FAIL queue_drained actual=%0d required=0", expQ.size());
    end
  endtask

  initial begin
    for (int i = 0; i < NREG; i++) model[i] = 32'd0;
    test_reset();
    test_bypass();
    test_zero_reg();
    test_link();
    test_raw();
    test_waw();
    test_saturate_reset();
    test_back_to_back();
    checkOutput();
    $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFail);
    $finish;
  end

endmodule
